// File: rtl/ser2par.sv
// Serial-to-parallel deserializer with a registered valid/ready output and sticky overflow.
// Optional even-parity check bit per word is enabled by defining SER2PAR_PARITY_EN.
module ser2par #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  data_serial_i,
    input  logic                  data_valid_i,
    input  logic                  par_ready_i,
    output logic [DATA_WIDTH-1:0] data_parallel_o,
    output logic                  par_valid_o,
    output logic                  overflow_o,
    output logic                  parity_err_o
);

    localparam int unsigned     CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  perr_q, perr_d;

    logic                  word_done;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_perr;

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shift_q[DATA_WIDTH-2:0], data_serial_i};
        end else begin
            shifted = {data_serial_i, shift_q[DATA_WIDTH-1:1]};
        end
    end

`ifdef SER2PAR_PARITY_EN
    typedef enum logic {StCollect, StParity} state_e;
    state_e state_q, state_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        word      = shift_q;
        word_perr = 1'b0;
        if (data_valid_i) begin
            unique case (state_q)
                StCollect: begin
                    shift_d = shifted;
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = StParity;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StParity: begin
                    // Data bits are already in shift_q; this bit is only the check bit.
                    word_done = 1'b1;
                    word_perr = ^{shift_q, data_serial_i};
                    state_d   = StCollect;
                end
                default: state_d = StCollect;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end
`else
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        word      = shifted;
        word_perr = 1'b0;
        if (data_valid_i) begin
            shift_d = shifted;
            if (cnt_q == CntLast) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end
`endif

    // A handshake frees the output register on the same edge a new word may load.
    always_comb begin
        valid_d = valid_q & ~par_ready_i;
        data_d  = data_q;
        perr_d  = perr_q;
        ovf_d   = ovf_q;
        if (word_done) begin
            if (!valid_q || par_ready_i) begin
                data_d  = word;
                perr_d  = word_perr;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
        end
    end

    assign data_parallel_o = data_q;
    assign par_valid_o     = valid_q;
    assign overflow_o      = ovf_q;
    assign parity_err_o    = perr_q;

endmodule
